// File: rtl/dsi_csr_regfile.sv
// rtl/dsi_csr_regfile.sv - DSI command/status register file with command FIFO and send FSM
//
// Purpose: CSR block for the DSI host. It holds the control and timing registers,
// a 16 x 8 command payload FIFO, and a small FSM that hands a command header to
// the packet assembler and then tracks its payload pops.
//
// Ports:
//   clk_csr_i      CSR clock; all state updates on its rising edge
//   rst_i          synchronous active-high reset
//   csr_adr_i      register address (0x0..0xF)
//   csr_dat_i      write data
//   csr_wr_i       single-cycle write strobe
//   csr_dat_o      registered read data for csr_adr_i
//   ctrl_en_o      core enable (CTRL bit0)
//   ctrl_lp_o      LP command mode (CTRL bit1)
//   timing_o       TIMING registers 0x2..0x7, 0x7 in the top byte
//   cmd_valid_o    command header valid
//   cmd_ready_i    command header accepted by the assembler
//   cmd_di_o       latched data identifier
//   cmd_len_o      latched payload length
//   cmd_data_o     payload byte at the FIFO head (0x00 when empty)
//   cmd_data_rd_i  payload pop strobe
//   cmd_done_i     end-of-packet pulse
//
// Configuration macro: DSI_CSR_FIFO_LEVEL_EN - when defined, 0xC reads the FIFO
// fill level; otherwise 0xC reads 0x00.

module dsi_csr_regfile (
   input  logic        clk_csr_i,
   input  logic        rst_i,
   input  logic [3:0]  csr_adr_i,
   input  logic [7:0]  csr_dat_i,
   input  logic        csr_wr_i,
   output logic [7:0]  csr_dat_o,
   output logic        ctrl_en_o,
   output logic        ctrl_lp_o,
   output logic [47:0] timing_o,
   output logic        cmd_valid_o,
   input  logic        cmd_ready_i,
   output logic [7:0]  cmd_di_o,
   output logic [7:0]  cmd_len_o,
   output logic [7:0]  cmd_data_o,
   input  logic        cmd_data_rd_i,
   input  logic        cmd_done_i
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_REQ       = 2'd1,
      S_PAYLOAD   = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t      state;
   logic [1:0]  ctrl_q;
   logic [47:0] timing_q;
   logic [7:0]  cmd_di_q;
   logic [7:0]  cmd_len_q;
   logic [7:0]  remaining;
   logic        overflow_q;
   logic        underflow_q;

   logic [7:0]  fifo_mem [16];
   logic [3:0]  wr_ptr;
   logic [3:0]  rd_ptr;
   logic [4:0]  count;

   logic        wr_ctrl, wr_status, wr_push, wr_go;
   logic        soft_rst;
   logic        fifo_empty, fifo_full;
   logic        do_push, do_pop;
   logic        ovf_set, udf_set;
   logic        busy;
   logic [7:0]  status;
   logic [7:0]  rd_mux;

   assign wr_ctrl   = csr_wr_i && (csr_adr_i == 4'h0);
   assign wr_status = csr_wr_i && (csr_adr_i == 4'h1);
   assign wr_push   = csr_wr_i && (csr_adr_i == 4'hA);
   assign wr_go     = csr_wr_i && (csr_adr_i == 4'hB);
   assign soft_rst  = wr_ctrl && csr_dat_i[7];

   assign fifo_empty = (count == 5'd0);
   assign fifo_full  = (count == 5'd16);

   // A pop in the same cycle frees a slot, so a push into a full FIFO is
   // accepted when paired with a pop; overflow only fires when nothing drains.
   assign do_pop  = cmd_data_rd_i && !fifo_empty;
   assign do_push = wr_push && (!fifo_full || do_pop);
   assign ovf_set = wr_push && fifo_full && !do_pop;
   assign udf_set = cmd_data_rd_i && fifo_empty;

   assign busy   = (state != S_IDLE);
   assign status = {3'b000, underflow_q, overflow_q, busy, fifo_full, fifo_empty};

   assign ctrl_en_o  = ctrl_q[0];
   assign ctrl_lp_o  = ctrl_q[1];
   assign timing_o   = timing_q;
   assign cmd_data_o = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

   // Plain register bank; soft reset leaves these untouched apart from CTRL.
   always_ff @(posedge clk_csr_i) begin
      if (rst_i) begin
         ctrl_q    <= 2'b00;
         timing_q  <= 48'h0;
         cmd_di_q  <= 8'h00;
         cmd_len_q <= 8'h00;
      end else if (csr_wr_i) begin
         case (csr_adr_i)
            4'h0: ctrl_q              <= csr_dat_i[1:0];
            4'h2: timing_q[7:0]       <= csr_dat_i;
            4'h3: timing_q[15:8]      <= csr_dat_i;
            4'h4: timing_q[23:16]     <= csr_dat_i;
            4'h5: timing_q[31:24]     <= csr_dat_i;
            4'h6: timing_q[39:32]     <= csr_dat_i;
            4'h7: timing_q[47:40]     <= csr_dat_i;
            4'h8: cmd_di_q            <= csr_dat_i;
            4'h9: cmd_len_q           <= csr_dat_i;
            default: ;
         endcase
      end
   end

   // FIFO storage needs no reset: an empty FIFO masks the head byte.
   always_ff @(posedge clk_csr_i) begin
      if (!rst_i && !soft_rst && do_push)
         fifo_mem[wr_ptr] <= csr_dat_i;
   end

   always_ff @(posedge clk_csr_i) begin
      if (rst_i || soft_rst) begin
         wr_ptr <= 4'd0;
         rd_ptr <= 4'd0;
         count  <= 5'd0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 4'd1;
         if (do_pop)
            rd_ptr <= rd_ptr + 4'd1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: ;
         endcase
      end
   end

   // Sticky flags: a set event in the same cycle beats a W1C clear.
   always_ff @(posedge clk_csr_i) begin
      if (rst_i || soft_rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= ovf_set | (overflow_q  & ~(wr_status & csr_dat_i[3]));
         underflow_q <= udf_set | (underflow_q & ~(wr_status & csr_dat_i[4]));
      end
   end

   always_ff @(posedge clk_csr_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         cmd_valid_o <= 1'b0;
         cmd_di_o    <= 8'h00;
         cmd_len_o   <= 8'h00;
         remaining   <= 8'h00;
      end else if (soft_rst) begin
         state       <= S_IDLE;
         cmd_valid_o <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (wr_go) begin
                  state       <= S_REQ;
                  cmd_valid_o <= 1'b1;
                  cmd_di_o    <= cmd_di_q;
                  cmd_len_o   <= cmd_len_q;
                  remaining   <= cmd_len_q;
               end
            end
            S_REQ: begin
               if (cmd_ready_i) begin
                  cmd_valid_o <= 1'b0;
                  state       <= (cmd_len_o != 8'h00) ? S_PAYLOAD : S_WAIT_DONE;
               end
            end
            S_PAYLOAD: begin
               if (cmd_data_rd_i) begin
                  remaining <= remaining - 8'd1;
                  if (remaining == 8'd1)
                     state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (cmd_done_i)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_mux = 8'h00;
      case (csr_adr_i)
         4'h0: rd_mux = {6'b000000, ctrl_q};
         4'h1: rd_mux = status;
         4'h2: rd_mux = timing_q[7:0];
         4'h3: rd_mux = timing_q[15:8];
         4'h4: rd_mux = timing_q[23:16];
         4'h5: rd_mux = timing_q[31:24];
         4'h6: rd_mux = timing_q[39:32];
         4'h7: rd_mux = timing_q[47:40];
         4'h8: rd_mux = cmd_di_q;
         4'h9: rd_mux = cmd_len_q;
`ifdef DSI_CSR_FIFO_LEVEL_EN
         4'hC: rd_mux = {3'b000, count};
`else
         4'hC: rd_mux = 8'h00;
`endif
         default: rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk_csr_i) begin
      if (rst_i)
         csr_dat_o <= 8'h00;
      else
         csr_dat_o <= rd_mux;
   end

endmodule
